// File: rtl/if_id_pipe_stage.sv
// if_id_pipe_stage: IF->ID elastic pipeline register with valid/ready handshake, stalls, flush,
// optional one-entry skid buffer and a saturating stall-cycle counter.
module if_id_pipe_stage #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter bit                 SKID_EN   = 1'b1,
    parameter int                 STAT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               stall_i,
    input  logic               mem_stall_i,
    output logic               out_valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [STAT_W-1:0]  stall_cnt_o
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d, skid_instr_q, skid_instr_d;
    logic [STAT_W-1:0]  cnt_q;
    logic               ready_q, adv, consume, accept;

    assign adv         = ~stall_i & ~mem_stall_i;
    assign out_valid_o = state_q != EMPTY;
    assign consume     = out_valid_o & adv;
    // With the skid buffer, ready comes straight from a flop so decode stalls never reach fetch.
    assign in_ready_o  = SKID_EN ? ready_q : (~out_valid_o | adv);
    assign accept      = in_valid_i & in_ready_o;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign stall_cnt_o = cnt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush_i) begin
            state_d      = EMPTY;
            pc_d         = '0;
            instr_d      = NOP_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        pc_d    = pc_i;
                        instr_d = instr_i;
                    end
                end
                FULL: begin
                    if (consume && accept) begin
                        pc_d    = pc_i;
                        instr_d = instr_i;
                    end else if (consume) begin
                        state_d = EMPTY;
                        pc_d    = '0;
                        instr_d = NOP_INSTR;
                    end else if (accept && SKID_EN) begin
                        state_d      = SKID;
                        skid_pc_d    = pc_i;
                        skid_instr_d = instr_i;
                    end
                end
                SKID: begin
                    if (consume) begin
                        state_d = FULL;
                        pc_d    = skid_pc_q;
                        instr_d = skid_instr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            pc_q         <= '0;
            instr_q      <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            ready_q      <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ready_q      <= state_d != SKID;
            cnt_q        <= (out_valid_o && !adv && !flush_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        end
    end
endmodule
